compare_seq: RTL and testbench
==============================

COMPARE_SEQ -- requirements
Module: compare_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range is 2 to 32.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Rst  input  1  asynchronous, active-high reset.
REQ-004 DataIn  input  WIDTH  operand bus, shared by both external PIPO operand registers.
REQ-005 InValid  input  1  DataIn holds a valid operand.
REQ-006 InReady  output  1  block accepts an operand this cycle.
REQ-007 EnA  output  1  load-enable for operand register A.
REQ-008 EnB  output  1  load-enable for operand register B.
REQ-009 RegA  input  WIDTH  readback of operand register A output.
REQ-010 RegB  input  WIDTH  readback of operand register B output.
REQ-011 Abort  input  1  synchronous abort of the current sequence.
REQ-012 Gt, Eq, Lt  output  1 each  registered comparison result.
REQ-013 OutValid  output  1  result valid.
REQ-014 OutReady  input  1  consumer takes the result.
REQ-015 CmpCount  output  8  number of results consumed, modulo 256.

Function
REQ-016 The FSM SHALL have four states: WAIT_A, WAIT_B, CMP and HOLD.
REQ-017 InReady SHALL be 1 in WAIT_A and WAIT_B, and 0 in CMP and HOLD.
REQ-018 An operand is accepted when InValid and InReady are both 1 on a rising edge.
REQ-019 EnA SHALL equal (state==WAIT_A & InValid & ~Abort); on acceptance the FSM moves WAIT_A->WAIT_B.
REQ-020 EnB SHALL equal (state==WAIT_B & InValid & ~Abort); on acceptance the FSM moves WAIT_B->CMP.
REQ-021 EnA and EnB SHALL be combinational, one cycle per accepted operand, and never 1 together.
REQ-022 Without an accept, the FSM SHALL hold in WAIT_A or WAIT_B indefinitely.
REQ-023 CMP SHALL last exactly one cycle.
- In CMP, RegA and RegB are compared and the result is registered into Gt/Eq/Lt.
- The FSM then moves to HOLD, and OutValid is 1 from the next cycle.
REQ-024 Latency: if B is accepted at edge N, OutValid SHALL be 1 after edge N+2.
REQ-025 Exactly one of Gt, Eq or Lt SHALL be 1 whenever OutValid is 1.
REQ-026 In HOLD, Gt/Eq/Lt and OutValid SHALL stay stable until OutReady is 1.
REQ-027 On that edge the FSM SHALL go HOLD->WAIT_A, OutValid SHALL go 0, and CmpCount SHALL increment.
REQ-028 CmpCount SHALL wrap from 255 to 0.
REQ-029 Abort=1 in any state SHALL, at the next edge:
- move the FSM to WAIT_A;
- clear OutValid, Gt, Eq and Lt;
- leave CmpCount unchanged.
REQ-030 Abort SHALL take priority over a simultaneous accept or OutReady.
- EnA/EnB stay 0 that cycle.
- A dropped result does not count.
REQ-031 OutReady while OutValid is 0 SHALL have no effect.

Reset
REQ-032 Rst=1 SHALL asynchronously force:
- the FSM to WAIT_A;
- Gt, Eq, Lt, OutValid and CmpCount to 0.
REQ-033 While Rst=1, InReady SHALL be 1 and EnA/EnB SHALL follow REQ-019 and REQ-020 in WAIT_A.
REQ-034 Reset mid-sequence SHALL discard partial operands; register contents are not cleared by this block.

Configuration
REQ-035 With macro CMP_SIGNED_EN defined, RegA and RegB SHALL be compared as two's-complement signed values.
REQ-036 Without CMP_SIGNED_EN, the comparison SHALL be unsigned.
REQ-037 The macro SHALL change no other behaviour.

Verification
REQ-038 WIDTH=8, unsigned build: A=0x05, B=0x03, OutReady=1 held:
- EnA pulses, then EnB pulses;
- Gt=1 two cycles after the B accept;
- CmpCount goes 0->1.
REQ-039 A=0x80, B=0x7F: unsigned build gives Gt=1; build with CMP_SIGNED_EN gives Lt=1.
REQ-040 A=B=0x3C with OutReady=0 for 5 cycles:
- Eq=1 and OutValid=1 stay stable;
- InReady=0 throughout;
- OutReady=1 then returns the FSM to WAIT_A.
REQ-041 Abort asserted with InValid=1 in WAIT_B:
- EnB=0 that cycle;
- next state is WAIT_A;
- no OutValid;
- CmpCount unchanged.
REQ-042 256 back-to-back compares: CmpCount wraps to 0.
- Rst pulsed in HOLD: OutValid drops immediately without waiting for a clock edge, and CmpCount reads 0.

Source files
------------

// File: rtl/compare_seq_if.sv
// Operand/result handshake bundle for compare_seq: shared operand bus, enables
// for the two external operand registers, their readback, and the result channel.
interface compare_seq_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             in_valid;
  logic             in_ready;
  logic             en_a;
  logic             en_b;
  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;
  logic             abort;
  logic             gt;
  logic             eq;
  logic             lt;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       cmp_count;

  modport master (
    output data_in, in_valid, reg_a, reg_b, abort, out_ready,
    input  in_ready, en_a, en_b, gt, eq, lt, out_valid, cmp_count
  );

  modport slave (
    input  data_in, in_valid, reg_a, reg_b, abort, out_ready,
    output in_ready, en_a, en_b, gt, eq, lt, out_valid, cmp_count
  );
endinterface

// File: rtl/compare_seq.sv
// Two-operand sequencer: loads A then B into external registers, compares them,
// holds the result until consumed. Define CMP_SIGNED_EN for a signed comparison.
module compare_seq #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  compare_seq_if.slave bus
);

  typedef enum logic [1:0] {WAIT_A, WAIT_B, CMP, HOLD} state_t;

  state_t     state;
  logic [2:0] res_p0;
  logic       vld_p1;
  logic [7:0] count;

  // Returns {gt, eq, lt}; exactly one bit is set.
  function automatic logic [2:0] compare(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef CMP_SIGNED_EN
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    sa = signed'(a);
    sb = signed'(b);
    compare = {sa > sb, sa == sb, sa < sb};
`else
    compare = {a > b, a == b, a < b};
`endif
  endfunction

  assign bus.in_ready  = (state == WAIT_A) || (state == WAIT_B);
  assign bus.en_a      = (state == WAIT_A) & bus.in_valid & ~bus.abort;
  assign bus.en_b      = (state == WAIT_B) & bus.in_valid & ~bus.abort;
  assign bus.gt        = res_p0[2];
  assign bus.eq        = res_p0[1];
  assign bus.lt        = res_p0[0];
  assign bus.out_valid = vld_p1;
  assign bus.cmp_count = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= WAIT_A;
      res_p0 <= '0;
      vld_p1 <= 1'b0;
      count  <= '0;
    end else if (bus.abort) begin
      state  <= WAIT_A;
      res_p0 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      case (state)
        WAIT_A: if (bus.in_valid) state <= WAIT_B;
        WAIT_B: if (bus.in_valid) state <= CMP;
        // p0: B is now in its register; capture the comparison
        CMP: begin
          res_p0 <= compare(bus.reg_a, bus.reg_b);
          state  <= HOLD;
        end
        // p1: publish the result, then wait for the consumer
        HOLD: begin
          if (!vld_p1) begin
            vld_p1 <= 1'b1;
          end else if (bus.out_ready) begin
            vld_p1 <= 1'b0;
            res_p0 <= '0;
            count  <= count + 8'd1;
            state  <= WAIT_A;
          end
        end
        default: state <= WAIT_A;
      endcase
    end
  end

endmodule

// File: tb/tb_compare_seq.sv
// Directed bench for compare_seq with behavioural operand registers A and B.
module tb_compare_seq;

  logic clk;
  logic rst;
  logic [7:0] ra, rb;
  int n_cmp = 0;
  int n_err = 0;

`ifdef CMP_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  compare_seq_if #(.WIDTH(8)) bus ();

  compare_seq #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign bus.reg_a = ra;
  assign bus.reg_b = rb;

  always_ff @(posedge clk) begin
    if (bus.en_a) ra <= bus.data_in;
    if (bus.en_b) rb <= bus.data_in;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Drives A then B; returns 1ns after the edge that accepts B.
  task automatic load_operands(input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.data_in  = a;
    tick();
    bus.data_in  = b;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.data_in = 8'h00; bus.abort = 1'b0; bus.out_ready = 1'b0;
    #1;
    chk("rst_in_ready", {7'd0, bus.in_ready}, 8'd1);
    chk("rst_out_valid", {7'd0, bus.out_valid}, 8'd0);
    chk("rst_flags", {5'd0, bus.gt, bus.eq, bus.lt}, 8'd0);
    chk("rst_count", bus.cmp_count, 8'd0);
    bus.in_valid = 1'b1;
    #1;
    chk("rst_en_a", {6'd0, bus.en_a, bus.en_b}, 8'b10);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.data_in = 8'h05;
    #1;
    chk("basic_en_a", {6'd0, bus.en_a, bus.en_b}, 8'b10);
    tick();
    bus.data_in = 8'h03;
    #1;
    chk("basic_en_b", {6'd0, bus.en_a, bus.en_b}, 8'b01);
    chk("basic_ready_b", {7'd0, bus.in_ready}, 8'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("basic_cmp_ready", {7'd0, bus.in_ready}, 8'd0);
    chk("basic_cmp_valid", {7'd0, bus.out_valid}, 8'd0);
    tick();
    chk("basic_n1_valid", {7'd0, bus.out_valid}, 8'd0);
    tick();
    chk("basic_n2_valid", {7'd0, bus.out_valid}, 8'd1);
    chk("basic_n2_flags", {5'd0, bus.gt, bus.eq, bus.lt}, 8'b100);
    chk("basic_n2_count", bus.cmp_count, 8'd0);
    tick();
    chk("basic_done_valid", {7'd0, bus.out_valid}, 8'd0);
    chk("basic_done_count", bus.cmp_count, 8'd1);
    chk("basic_done_ready", {7'd0, bus.in_ready}, 8'd1);
  endtask

  task automatic test_signed();
    bus.out_ready = 1'b1;
    load_operands(8'h80, 8'h7F);
    tick();
    tick();
    chk("sign_valid", {7'd0, bus.out_valid}, 8'd1);
    chk("sign_flags", {5'd0, bus.gt, bus.eq, bus.lt}, SGN ? 8'b001 : 8'b100);
    tick();
    chk("sign_count", bus.cmp_count, 8'd2);
  endtask

  task automatic test_hold();
    bus.out_ready = 1'b0;
    load_operands(8'h3C, 8'h3C);
    tick();
    tick();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {7'd0, bus.out_valid}, 8'd1);
      chk("hold_flags", {5'd0, bus.gt, bus.eq, bus.lt}, 8'b010);
      chk("hold_ready", {7'd0, bus.in_ready}, 8'd0);
      chk("hold_en", {6'd0, bus.en_a, bus.en_b}, 8'b00);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("hold_release_valid", {7'd0, bus.out_valid}, 8'd0);
    chk("hold_release_ready", {7'd0, bus.in_ready}, 8'd1);
    chk("hold_release_count", bus.cmp_count, 8'd3);
  endtask

  task automatic test_abort();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.data_in = 8'h11;
    tick();
    bus.data_in = 8'h22; bus.abort = 1'b1;
    #1;
    chk("abort_en", {6'd0, bus.en_a, bus.en_b}, 8'b00);
    tick();
    bus.abort = 1'b0; bus.in_valid = 1'b0;
    chk("abort_state_ready", {7'd0, bus.in_ready}, 8'd1);
    bus.in_valid = 1'b1;
    #1;
    chk("abort_wait_a", {6'd0, bus.en_a, bus.en_b}, 8'b10);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_valid", {7'd0, bus.out_valid}, 8'd0);
    end
    chk("abort_count", bus.cmp_count, 8'd3);
    // abort in HOLD beats a simultaneous out_ready
    bus.out_ready = 1'b0;
    load_operands(8'h01, 8'h09);
    tick();
    tick();
    chk("abort_hold_pre", {7'd0, bus.out_valid}, 8'd1);
    bus.abort = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_hold_valid", {7'd0, bus.out_valid}, 8'd0);
    chk("abort_hold_flags", {5'd0, bus.gt, bus.eq, bus.lt}, 8'b000);
    chk("abort_hold_count", bus.cmp_count, 8'd3);
    chk("abort_hold_ready", {7'd0, bus.in_ready}, 8'd1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 253; i++) begin
      a = 8'(i % 128);
      load_operands(a, 8'd64);
      tick();
      tick();
      chk("b2b_valid", {7'd0, bus.out_valid}, 8'd1);
      chk("b2b_flags", {5'd0, bus.gt, bus.eq, bus.lt},
          (a > 8'd64) ? 8'b100 : ((a == 8'd64) ? 8'b010 : 8'b001));
      tick();
      if (i == 251) chk("b2b_count_ff", bus.cmp_count, 8'hFF);
    end
    chk("b2b_wrap", bus.cmp_count, 8'd0);
  endtask

  task automatic test_reset_hold();
    bus.out_ready = 1'b1;
    load_operands(8'h10, 8'h20);
    tick();
    tick();
    tick();
    chk("rh_count1", bus.cmp_count, 8'd1);
    bus.out_ready = 1'b0;
    load_operands(8'h01, 8'h02);
    tick();
    tick();
    chk("rh_pre_valid", {7'd0, bus.out_valid}, 8'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rh_async_valid", {7'd0, bus.out_valid}, 8'd0);
    chk("rh_async_count", bus.cmp_count, 8'd0);
    chk("rh_async_flags", {5'd0, bus.gt, bus.eq, bus.lt}, 8'b000);
    chk("rh_async_ready", {7'd0, bus.in_ready}, 8'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    ra = 8'h00;
    rb = 8'h00;
    test_reset();
    test_basic();
    test_signed();
    test_hold();
    test_abort();
    test_back_to_back();
    test_reset_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
